// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong buffer controller: write FSM fills frames, read FSM hands them to a consumer.
// Optional producer-stall counter enabled by defining PINGPONG_STALL_CNT_EN.
//
// state   | meaning
// W_IDLE  | waiting for a free buffer half (fill_cnt < 2)
// W_FILL  | accepting producer words for the current frame
// W_CLOSE | last word presented; write enable drops after this cycle
// R_IDLE  | waiting for a consumer start with a frame available
// R_BUSY  | consumer owns a frame, read enable high
// R_CLOSE | read enable low for one cycle, frame released
module pingpong_buf_ctrl #(
  parameter int FRAME_LEN  = 784,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prod_valid,
  input  logic [WIDTH-1:0]      prod_data,
  output logic                  prod_ready,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [WIDTH-1:0]      buf_wr_data,
  input  logic                  cons_start,
  input  logic                  cons_done,
  output logic                  frame_avail,
  output logic                  buf_rd_en,
  output logic [1:0]            fill_cnt
`ifdef PINGPONG_STALL_CNT_EN
  , output logic [15:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_CLOSE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_BUSY, R_CLOSE} r_state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  accept;
  logic                  last_word;
  logic                  wr_close_entry;
  logic                  rd_close_entry;

  assign accept         = prod_valid & prod_ready;
  assign last_word      = (addr_cnt == LAST_ADDR);
  assign wr_close_entry = accept & last_word;
  assign rd_close_entry = (r_state == R_BUSY) & cons_done;
  assign frame_avail    = (r_state == R_IDLE) & (fill_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next     = w_state;
    prod_ready = 1'b0;
    case (w_state)
      W_IDLE:  if (fill_cnt < 2'd2) w_next = W_FILL;
      W_FILL: begin
        prod_ready = 1'b1;
        if (wr_close_entry) w_next = W_CLOSE;
      end
      W_CLOSE: w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (cons_start && frame_avail) r_next = R_BUSY;
      R_BUSY:  if (cons_done) r_next = R_CLOSE;
      R_CLOSE: r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Write enable stays high across producer gaps and drops on leaving W_CLOSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt    <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
    end else if (accept) begin
      buf_wr_en   <= 1'b1;
      buf_wr_addr <= addr_cnt;
      buf_wr_data <= prod_data;
      addr_cnt    <= last_word ? '0 : addr_cnt + 1'b1;
    end else if (w_state == W_CLOSE) begin
      buf_wr_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_rd_en <= 1'b0;
    else        buf_rd_en <= (r_next == R_BUSY);
  end

  // Bounded by the FSM handshakes, so no saturation is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= 2'd0;
    end else begin
      case ({wr_close_entry, rd_close_entry})
        2'b10:   fill_cnt <= fill_cnt + 2'd1;
        2'b01:   fill_cnt <= fill_cnt - 2'd1;
        default: fill_cnt <= fill_cnt;
      endcase
    end
  end

`ifdef PINGPONG_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= 16'd0;
    else if (prod_valid && !prod_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
